// File: rtl/chaos_byte_gen_if.sv
// Request/stream bundle between a chaos_byte_gen and whoever starts it and consumes its bytes.
// master drives the request and ready; slave is the generator side.
interface chaos_byte_gen_if;
  logic        start;
  logic [15:0] seed_in;
  logic [15:0] r_in;
  logic [15:0] len_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, seed_in, r_in, len_in, byte_ready,
    input  byte_out, byte_valid, busy, done
  );

  modport slave (
    input  start, seed_in, r_in, len_in, byte_ready,
    output byte_out, byte_valid, busy, done
  );
endinterface

// File: rtl/chaos_byte_gen.sv
// Logistic-map byte generator: x <- r*x*(1-x) in fixed point, two cycles per iterate, burn-in then len bytes.
// First byte 2*(BURN+1)+1 cycles after start; byte held and iterator stalled while byte_ready is low.
module chaos_byte_gen #(
  parameter int unsigned BURN = 32
) (
  input  logic            clk,
  input  logic            rst,
  chaos_byte_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;

  localparam logic [7:0] BURN_INIT = 8'(BURN);

  state_t      state_q;
  logic [15:0] x_q;
  logic [15:0] r_q;
  logic [15:0] t_q;
  logic [15:0] rem_q;
  logic [7:0]  burn_q;
  logic [7:0]  byte_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [32:0] prod1;
  logic [31:0] prod2;
  logic [15:0] t_d;
  logic [15:0] x_d;

  // x*(1-x) peaks at 0.25, so the Q0.16 result never exceeds 16'h4000
  always_comb begin
    prod1 = {17'd0, x_q} * (33'h1_0000 - {17'd0, x_q});
    t_d   = prod1[31:16];
    prod2 = {16'd0, r_q} * {16'd0, t_q};
    x_d   = (prod2[29:14] == 16'h0000) ? 16'h0001 : prod2[29:14];
  end

  logic unused_bits;
  assign unused_bits = ^{prod1[32], prod1[15:0], prod2[31:30], prod2[13:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 16'h0000;
      r_q     <= 16'h0000;
      t_q     <= 16'h0000;
      rem_q   <= 16'h0000;
      burn_q  <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len_in == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              x_q     <= (bus.seed_in == 16'h0000) ? 16'h0001 : bus.seed_in;
              r_q     <= bus.r_in;
              rem_q   <= bus.len_in;
              burn_q  <= BURN_INIT;
              busy_q  <= 1'b1;
              state_q <= MUL1;
            end
          end
        end
        MUL1: begin
          t_q     <= t_d;
          state_q <= MUL2;
        end
        MUL2: begin
          x_q <= x_d;
          if (burn_q != 8'd0) begin
            burn_q  <= burn_q - 8'd1;
            state_q <= MUL1;
          end else begin
            byte_q  <= x_d[15:8] ^ x_d[7:0];
            valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (valid_q && bus.byte_ready) begin
            valid_q <= 1'b0;
            rem_q   <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= MUL1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_chaos_byte_gen.sv
// Directed bench for chaos_byte_gen: one BURN=0 and one BURN=2 instance share the same stimulus.
module tb_chaos_byte_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start;
  logic        byte_ready;
  logic [15:0] seed_in;
  logic [15:0] r_in;
  logic [15:0] len_in;

  chaos_byte_gen_if b0 ();
  chaos_byte_gen_if b2 ();

  assign b0.start      = start;
  assign b0.seed_in    = seed_in;
  assign b0.r_in       = r_in;
  assign b0.len_in     = len_in;
  assign b0.byte_ready = byte_ready;
  assign b2.start      = start;
  assign b2.seed_in    = seed_in;
  assign b2.r_in       = r_in;
  assign b2.len_in     = len_in;
  assign b2.byte_ready = byte_ready;

  chaos_byte_gen #(.BURN(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  chaos_byte_gen #(.BURN(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int n_chk;
  int n_pass;

  logic [7:0] g0_b [8];
  int         g0_c [8];
  logic [7:0] g2_b [8];
  int         g2_c [8];
  int n0, n2, d0, d2, nd0, nd2, hold;
  logic bz1, dbz0, dbz2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Cycle 0 is the start cycle; outputs are sampled and inputs driven at each falling edge.
  task automatic run(input logic [15:0] sd, input logic [15:0] rr, input logic [15:0] ln,
                     input int bp_at, input int bp_n, input int poke_at);
    n0 = 0; n2 = 0; d0 = -1; d2 = -1; nd0 = 0; nd2 = 0; hold = 0;
    bz1 = 1'b0; dbz0 = 1'b1; dbz2 = 1'b1;
    @(negedge clk);
    seed_in = sd; r_in = rr; len_in = ln; start = 1'b1; byte_ready = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start   = 1'b0;
      seed_in = sd;
      if (c == poke_at) begin
        start   = 1'b1;
        seed_in = 16'h1234;
      end
      byte_ready = !(c >= bp_at && c < bp_at + bp_n);
      if (c == 1) bz1 = b0.busy;
      if (!byte_ready && b0.byte_valid && b0.byte_out == 8'hA3) hold++;
      if (b0.byte_valid && byte_ready && n0 < 8) begin
        g0_b[n0] = b0.byte_out; g0_c[n0] = c; n0++;
      end
      if (b2.byte_valid && byte_ready && n2 < 8) begin
        g2_b[n2] = b2.byte_out; g2_c[n2] = c; n2++;
      end
      if (b0.done) begin
        nd0++;
        if (d0 < 0) begin d0 = c; dbz0 = b0.busy; end
      end
      if (b2.done) begin
        nd2++;
        if (d2 < 0) begin d2 = c; dbz2 = b2.busy; end
      end
      if (d0 >= 0 && d2 >= 0 && c > d0 + 1 && c > d2 + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic chk_case1(input string p, input int c0);
    chk({p, "_n"}, n0, 3);
    chk({p, "_b0"}, g0_b[0], 8'hA3);
    chk({p, "_b1"}, g0_b[1], 8'h88);
    chk({p, "_b2"}, g0_b[2], 8'h0F);
    chk({p, "_c0"}, g0_c[0], c0);
    chk({p, "_c1"}, g0_c[1], c0 + 3);
    chk({p, "_c2"}, g0_c[2], c0 + 6);
    chk({p, "_done"}, d0, c0 + 7);
    chk({p, "_done_w"}, nd0, 1);
    chk({p, "_busy_at_done"}, dbz0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    start = 1'b0; byte_ready = 1'b0; seed_in = 16'h0; r_in = 16'h0; len_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_byte", b0.byte_out, 8'h00);
    chk("rst_valid", b0.byte_valid, 1'b0);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_done", b0.done, 1'b0);
    chk("rst_busy2", b2.busy, 1'b0);
    rst = 1'b0;

    run(16'h8000, 16'hFF5C, 16'd3, 0, 0, 0);
    chk_case1("c1", 3);
    chk("c1_busy1", bz1, 1'b1);

    run(16'h8000, 16'hFF5C, 16'd1, 0, 0, 0);
    chk("c2_n", n2, 1);
    chk("c2_byte", g2_b[0], 8'h0F);
    chk("c2_cyc", g2_c[0], 7);
    chk("c2_done", d2, 8);
    chk("c2_busy_at_done", dbz2, 1'b0);
    chk("c2_b0_byte", g0_b[0], 8'hA3);
    chk("c2_b0_done", d0, 4);

    run(16'h0000, 16'hFF5C, 16'd4, 0, 0, 0);
    chk("z1_n", n0, 4);
    chk("z1_n2", n2, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("z1_b%0d", k), g0_b[k], 8'h01);
      chk($sformatf("z1_c%0d", k), g0_c[k], 3 + 3 * k);
      chk($sformatf("z1_b2_%0d", k), g2_b[k], 8'h01);
    end
    chk("z1_done", d0, 13);
    chk("z1_done2", d2, 17);

    run(16'h8000, 16'h0000, 16'd4, 0, 0, 0);
    chk("z2_n", n0, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("z2_b%0d", k), g0_b[k], 8'h01);
    chk("z2_done", d0, 13);

    run(16'h8000, 16'hFF5C, 16'd3, 3, 5, 0);
    chk("bp_hold", hold, 5);
    chk_case1("bp", 8);

    run(16'h8000, 16'hFF5C, 16'd3, 0, 0, 4);
    chk_case1("poke", 3);

    run(16'h8000, 16'hFF5C, 16'd0, 0, 0, 0);
    chk("l0_done", d0, 1);
    chk("l0_done2", d2, 1);
    chk("l0_done_w", nd0, 1);
    chk("l0_busy", bz1, 1'b0);
    chk("l0_busy_at_done", dbz0, 1'b0);
    chk("l0_nbytes", n0 + n2, 0);

    @(negedge clk);
    seed_in = 16'h8000; r_in = 16'hFF5C; len_in = 16'd3; start = 1'b1; byte_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", b0.byte_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", b0.byte_valid, 1'b0);
    chk("arst_busy", b0.busy, 1'b0);
    chk("arst_done", b0.done, 1'b0);
    chk("arst_busy2", b2.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run(16'h8000, 16'hFF5C, 16'd3, 0, 0, 0);
    chk_case1("post_rst", 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/chaos_byte_gen.md
# chaos_byte_gen

Fixed-point logistic-map byte generator feeding the duplicate-detection stage of the permutation/S-box path. After a `start` pulse it iterates x(n+1) = r·x(n)·(1−x(n)) from a seed. It discards a configurable burn-in, then emits exactly `len_in` bytes over a valid/ready handshake. One byte is folded from each post-burn-in iterate. The downstream uniqueness checker samples `byte_out` only on accepted transfers.

## Interface
- `BURN`, default 32: iterations discarded after `start` before the first emitted byte. Range 0..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `seed_in` in 16: initial x, unsigned Q0.16; sampled with `start`.
- `r_in` in 16: map parameter, unsigned Q2.14; sampled with `start`.
- `len_in` in 16: number of bytes to emit; sampled with `start`.
- `byte_out` out 8: output byte.
- `byte_valid` out 1: `byte_out` holds a valid byte.
- `byte_ready` in 1: downstream accepts the byte.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- Registers:
  - x: 16b, Q0.16.
  - r: 16b.
  - t: 16b.
  - burn counter: 8b.
  - remaining: 16b.
  - state.
- States: IDLE, MUL1, MUL2, OUT.
- IDLE, on `start`:
  - If `len_in` == 0: pulse `done` next cycle and stay IDLE.
  - Else: load x = `seed_in`, r = `r_in`, remaining = `len_in`, burn = `BURN`; go to MUL1.
  - Zero guard: a seed of 0 is loaded as 16'h0001.
- MUL1 computes t = (x · (17'h10000 − x)) >> 16.
  - Operands: 16b × 17b, 33b product.
  - Truncate; t ≤ 16'h4000, so it always fits 16b.
  - Go to MUL2.
- MUL2 computes q = r · t (32b) and x_next = q[29:14].
  - Truncation; q[31:30] are discarded.
  - If x_next == 0, store 16'h0001 instead. This prevents lock at the fixed point 0.
  - If burn ≠ 0: decrement burn and go to MUL1.
  - Else: register `byte_out` = x_next[15:8] ^ x_next[7:0], assert `byte_valid`, go to OUT.
- OUT, on handshake (`byte_valid` & `byte_ready`):
  - Deassert `byte_valid` next cycle and decrement remaining.
  - If remaining was 1: go to IDLE and pulse `done`.
  - Else: go to MUL1. No burn-in between bytes.
- `start` while `busy` is ignored and has no effect on any register.
- `r_in` ≥ 16'h10000·(4/4) is not possible: r < 4 by format, and r·t < 1.0 always. No overflow handling is required beyond the truncation rules above.

## Timing
- Reset values: state IDLE; `byte_out` = 8'h00; `byte_valid`, `busy`, `done` = 0; x, r, t, counters = 0.
- `rst` mid-operation aborts immediately. No `done` is produced, and any pending byte is dropped.
- `start` in cycle 0 gives:
  - MUL1 in cycle 1, with `busy` = 1 from cycle 1.
  - Each iteration takes 2 cycles.
  - First `byte_valid` in cycle 2·(BURN+1)+1.
- With `byte_ready` tied high, steady-state throughput is one byte per 3 cycles.
- Backpressure: while `byte_valid` & !`byte_ready`, `byte_out` and `byte_valid` stay stable and the iterator stalls.
- `done` is registered and asserted in the cycle after the final handshake. `busy` is 0 in that same cycle, and a new `start` is accepted in that same cycle.
- For `len_in` = 0, `done` is asserted in cycle 1 and `busy` stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- BURN=0, seed 16'h8000, r 16'hFF5C, len 3, ready=1:
  - Bytes 8'hA3, 8'h88, 8'h0F; `byte_valid` at cycles 3, 6, 9.
  - Internal x sequence FF5C, 028A, 0A05.
  - `done` at cycle 10.
- BURN=2, same seed and r, len 1 -> single byte 8'h0F at cycle 7, then `done` at cycle 8.
- BURN=0, seed 16'h0000, r 16'hFF5C, len 4 -> zero guard holds x at 0001, bytes are all 8'h01. Same result for seed 16'h8000, r 16'h0000.
- Backpressure: case 1 with `byte_ready` low for 5 cycles while `byte_out` = A3 -> `byte_out` and `byte_valid` held, then the same sequence resumes with no byte lost or duplicated.
- `start` pulsed mid-run with a different seed -> ignored, output identical to case 1. `len_in` = 0 -> `done` only, no `byte_valid`.
- `rst` asserted in the OUT state -> `byte_valid`, `busy`, `done` drop asynchronously. A fresh run then reproduces case 1 exactly.
